// File: rtl/unique_draw_controller_pkg.sv
// Shared definitions for the unique draw controller: FSM encoding,
// parameter defaults and a small width helper.
package unique_draw_controller_pkg;

  localparam int DEF_WIDTH        = 8;
  localparam int DEF_MAX_DRAWS    = 8;
  localparam int DEF_REJECT_LIMIT = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    FIN   = 3'd4
  } state_e;

  // Index width for a table of 'depth' entries (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/unique_draw_controller_history.sv
// History of numbers accepted in the current request. Each entry has a
// valid bit; a clear wipes all valid bits in one cycle. The match output
// compares a candidate against every valid entry in parallel.
module draw_history
  import unique_draw_controller_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_MAX_DRAWS,
  parameter int IDX_W = idx_width(DEF_MAX_DRAWS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] cmp_data,
  output logic             match
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Valid bits: cleared by reset or by a new request, set on write.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Data storage for accepted numbers.
  // NOTE: the data array is not reset; an entry only counts once its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Parallel compare of the candidate against all valid entries.
  // NOTE: the output gets a default before the loop so no latch is inferred.
  always_comb begin
    match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (mem[i] == cmp_data)) begin
        match = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unique_draw_controller.sv
// Draws cnt_cfg distinct numbers in [min_cfg, max_cfg] from an external
// random generator, rejecting duplicates and out-of-range samples, and
// giving up after REJECT_LIMIT consecutive rejects.
module unique_draw_controller
  import unique_draw_controller_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int MAX_DRAWS    = DEF_MAX_DRAWS,
  parameter int REJECT_LIMIT = DEF_REJECT_LIMIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       cnt_cfg,
  input  logic [WIDTH-1:0] min_cfg,
  input  logic [WIDTH-1:0] max_cfg,
  output logic             rnd_en,
  output logic [WIDTH-1:0] rnd_min,
  output logic [WIDTH-1:0] rnd_max,
  input  logic [WIDTH-1:0] rnd_num,
  output logic             draw_valid,
  output logic [WIDTH-1:0] draw_num,
  output logic [2:0]       draw_idx,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_timeout
);

  localparam int IDX_W = idx_width(MAX_DRAWS);
  localparam int REJ_W = $clog2(REJECT_LIMIT + 1);
  localparam logic [REJ_W-1:0] REJ_LAST = REJ_W'(REJECT_LIMIT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q;
  logic [3:0]       acc_q;
  logic [3:0]       acc_next;
  logic [REJ_W-1:0] rej_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH:0]   span;
  logic             cfg_ok;
  logic             in_range;
  logic             hist_match;
  logic             latch_cfg, cfg_bad, take, drop, tmo, fin;

  assign rnd_en   = (state_q == REQ);
  assign busy     = (state_q != IDLE);
  assign acc_next = acc_q + 4'd1;
  assign in_range = (sample_q >= rnd_min) && (sample_q <= rnd_max);

  // Request validation; the range size needs one extra bit for a full-width span.
  always_comb begin
    span   = {1'b0, max_cfg} - {1'b0, min_cfg} + {{WIDTH{1'b0}}, 1'b1};
    cfg_ok = (cnt_cfg != 4'd0) && (int'(cnt_cfg) <= MAX_DRAWS) &&
             (max_cfg >= min_cfg) && (int'(span) >= int'(cnt_cfg));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and one-cycle action strobes; abort overrides everything while busy.
  always_comb begin
    state_d   = state_q;
    latch_cfg = 1'b0;
    cfg_bad   = 1'b0;
    take      = 1'b0;
    drop      = 1'b0;
    tmo       = 1'b0;
    fin       = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              latch_cfg = 1'b1;
              state_d   = REQ;
            end else begin
              cfg_bad = 1'b1;
            end
          end
        end
        REQ:  state_d = WAIT;
        WAIT: state_d = CHECK;
        CHECK: begin
          if (in_range && !hist_match) begin
            take    = 1'b1;
            state_d = (acc_next == cnt_q) ? FIN : REQ;
          end else begin
            drop = 1'b1;
            if (rej_q == REJ_LAST) begin
              tmo     = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = REQ;
            end
          end
        end
        FIN: begin
          fin     = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Latched config, counters, sample register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      rej_q       <= '0;
      sample_q    <= '0;
      rnd_min     <= '0;
      rnd_max     <= '1;
      draw_valid  <= 1'b0;
      draw_num    <= '0;
      draw_idx    <= '0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      draw_valid  <= take;
      done        <= fin;
      err_cfg     <= cfg_bad;
      err_timeout <= tmo;
      if (latch_cfg) begin
        cnt_q   <= cnt_cfg;
        rnd_min <= min_cfg;
        rnd_max <= max_cfg;
        acc_q   <= '0;
        rej_q   <= '0;
      end
      if (state_q == WAIT) begin
        sample_q <= rnd_num;
      end
      if (take) begin
        draw_num <= sample_q;
        draw_idx <= acc_q[2:0];
        acc_q    <= acc_next;
        rej_q    <= '0;
      end
      if (drop) begin
        rej_q <= rej_q + REJ_W'(1);
      end
    end
  end

  draw_history #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DRAWS),
    .IDX_W (IDX_W)
  ) u_history (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (latch_cfg),
    .wr_en    (take),
    .wr_idx   (acc_q[IDX_W-1:0]),
    .wr_data  (sample_q),
    .cmp_data (sample_q),
    .match    (hist_match)
  );

endmodule

// File: tb/tb_unique_draw_controller.sv
// Bench for unique_draw_controller: table of requests with expected
// outcomes, hand-written abort/reset sequences and random requests, all
// scored against a model that replays the generator's sample stream.
module tb_unique_draw_controller;

  localparam int WIDTH = 8;
  localparam int REJ   = 64;

  typedef enum int {GEN_LFSR, GEN_RAND, GEN_FORCE} gen_mode_e;
  typedef enum int {OUT_NONE, OUT_CFG, OUT_DONE, OUT_TMO, OUT_ANY} outcome_e;

  typedef struct {
    int        cnt;
    int        mn;
    int        mx;
    gen_mode_e mode;
    outcome_e  exp_out;
    int        exp_draws;
  } vec_t;

  logic             clk, rst_n, start, abort;
  logic [3:0]       cnt_cfg;
  logic [WIDTH-1:0] min_cfg, max_cfg;
  logic             rnd_en;
  logic [WIDTH-1:0] rnd_min, rnd_max, rnd_num;
  logic             draw_valid;
  logic [WIDTH-1:0] draw_num;
  logic [2:0]       draw_idx;
  logic             busy, done, err_cfg, err_timeout;

  int n_cmp = 0;
  int n_bad = 0;

  unique_draw_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .cnt_cfg     (cnt_cfg),
    .min_cfg     (min_cfg),
    .max_cfg     (max_cfg),
    .rnd_en      (rnd_en),
    .rnd_min     (rnd_min),
    .rnd_max     (rnd_max),
    .rnd_num     (rnd_num),
    .draw_valid  (draw_valid),
    .draw_num    (draw_num),
    .draw_idx    (draw_idx),
    .busy        (busy),
    .done        (done),
    .err_cfg     (err_cfg),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random generator: registers a new value on every rnd_en edge and logs it.
  gen_mode_e   gen_mode = GEN_LFSR;
  logic [15:0] lfsr = 16'hACE1;
  int          gen_q[$];

  initial rnd_num = '0;

  always @(posedge clk) begin : gen
    int lo, hi, v;
    if (rnd_en) begin
      lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      case (gen_mode)
        GEN_LFSR: v = int'(rnd_min) + (int'(lfsr) % (int'(rnd_max) - int'(rnd_min) + 1));
        GEN_RAND: begin
          lo = (int'(rnd_min) > 2) ? int'(rnd_min) - 2 : 0;
          hi = (int'(rnd_max) < 253) ? int'(rnd_max) + 2 : 255;
          v  = int'($urandom_range(hi, lo));
        end
        default:  v = 9;
      endcase
      rnd_num <= v[WIDTH-1:0];
      gen_q.push_back(v);
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic bit in_list(input int q[$], input int v);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Issue one request, monitor until the block has been idle for a while,
  // then score everything seen against the model.
  task automatic do_request(input int cnt, input int mn, input int mx, input gen_mode_e mode,
                            input outcome_e exp_out, input int exp_draws, input string tag);
    int got_num[$];
    int got_idx[$];
    int exp_num[$];
    int n_done, n_tmo, n_cfg, n_rnden, idle_run, rej, consumed, v;
    bit finished, rng_checked, ok_cfg;
    outcome_e model_out, dut_out;
    n_done = 0; n_tmo = 0; n_cfg = 0; n_rnden = 0; idle_run = 0;
    finished = 1'b0; rng_checked = 1'b0;
    gen_mode = mode;
    gen_q.delete();
    cnt_cfg = 4'(cnt);
    min_cfg = 8'(mn);
    max_cfg = 8'(mx);
    start   = 1'b1;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (draw_valid) begin
        got_num.push_back(int'(draw_num));
        got_idx.push_back(int'(draw_idx));
      end
      if (done)        n_done++;
      if (err_timeout) n_tmo++;
      if (err_cfg)     n_cfg++;
      if (rnd_en)      n_rnden++;
      if (busy && !rng_checked) begin
        rng_checked = 1'b1;
        check({tag, " rnd_min"}, int'(rnd_min), mn);
        check({tag, " rnd_max"}, int'(rnd_max), mx);
      end
      idle_run = busy ? 0 : idle_run + 1;
      if (idle_run >= 3) finished = 1'b1;
    end
    check({tag, " finished in budget"}, int'(finished), 1);

    // Model: validate the request, then replay the sample stream.
    ok_cfg    = (cnt >= 1) && (cnt <= 8) && (mx >= mn) && ((mx - mn + 1) >= cnt);
    consumed  = 0;
    rej       = 0;
    model_out = OUT_NONE;
    if (!ok_cfg) begin
      model_out = OUT_CFG;
    end else begin
      for (int k = 0; k < gen_q.size() && model_out == OUT_NONE; k++) begin
        v = gen_q[k];
        consumed++;
        if (v >= mn && v <= mx && !in_list(exp_num, v)) begin
          exp_num.push_back(v);
          rej = 0;
          if (exp_num.size() == cnt) model_out = OUT_DONE;
        end else begin
          rej++;
          if (rej == REJ) model_out = OUT_TMO;
        end
      end
    end

    dut_out = (n_cfg > 0) ? OUT_CFG : (n_tmo > 0) ? OUT_TMO : (n_done > 0) ? OUT_DONE : OUT_NONE;
    check({tag, " outcome vs model"}, int'(dut_out), int'(model_out));
    if (exp_out != OUT_ANY) begin
      check({tag, " outcome vs table"}, int'(dut_out), int'(exp_out));
      check({tag, " draws vs table"}, got_num.size(), exp_draws);
    end
    check({tag, " done pulses"}, n_done, (model_out == OUT_DONE) ? 1 : 0);
    check({tag, " timeout pulses"}, n_tmo, (model_out == OUT_TMO) ? 1 : 0);
    check({tag, " err_cfg pulses"}, n_cfg, (model_out == OUT_CFG) ? 1 : 0);
    check({tag, " rnd_en cycles"}, n_rnden, consumed);
    check({tag, " draw count"}, got_num.size(), exp_num.size());
    for (int i = 0; i < got_num.size() && i < exp_num.size(); i++) begin
      check($sformatf("%s draw_num[%0d]", tag, i), got_num[i], exp_num[i]);
      check($sformatf("%s draw_idx[%0d]", tag, i), got_idx[i], i);
    end
  endtask

  initial begin
    vec_t tbl [11];
    int   nv, n_cfg_seen, n_bad_out;
    bit   got_draw;

    tbl[0]  = '{4, 10, 20, GEN_LFSR,  OUT_DONE, 4};
    tbl[1]  = '{3, 5,  6,  GEN_LFSR,  OUT_CFG,  0};
    tbl[2]  = '{2, 7,  7,  GEN_LFSR,  OUT_CFG,  0};
    tbl[3]  = '{1, 7,  7,  GEN_LFSR,  OUT_DONE, 1};
    tbl[4]  = '{0, 0,  255, GEN_LFSR, OUT_CFG,  0};
    tbl[5]  = '{9, 0,  255, GEN_LFSR, OUT_CFG,  0};
    tbl[6]  = '{8, 0,  15, GEN_LFSR,  OUT_DONE, 8};
    tbl[7]  = '{2, 20, 10, GEN_LFSR,  OUT_CFG,  0};
    tbl[8]  = '{2, 0,  255, GEN_FORCE, OUT_TMO, 1};
    tbl[9]  = '{8, 0,  255, GEN_RAND, OUT_DONE, 8};
    tbl[10] = '{5, 250, 255, GEN_RAND, OUT_DONE, 5};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cnt_cfg = '0; min_cfg = '0; max_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset rnd_en", rnd_en, 0);
    check("reset draw_valid", draw_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset err_cfg", err_cfg, 0);
    check("reset err_timeout", err_timeout, 0);
    check("reset draw_num", draw_num, 0);
    check("reset draw_idx", draw_idx, 0);
    check("reset rnd_min", rnd_min, 0);
    check("reset rnd_max", rnd_max, 255);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 11; t++) begin
      do_request(tbl[t].cnt, tbl[t].mn, tbl[t].mx, tbl[t].mode, tbl[t].exp_out,
                 tbl[t].exp_draws, $sformatf("vec%0d", t));
    end

    // Abort one cycle after the second draw; a start while busy is ignored.
    gen_mode = GEN_LFSR;
    cnt_cfg = 4'd6; min_cfg = 8'd0; max_cfg = 8'd100; start = 1'b1;
    nv = 0; n_cfg_seen = 0; n_bad_out = 0;
    for (int cyc = 0; cyc < 2000 && nv < 2; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cnt_cfg = 4'd6;
      if (err_cfg) n_cfg_seen++;
      if (draw_valid) begin
        nv++;
        if (nv == 1) begin
          start   = 1'b1;
          cnt_cfg = 4'd0;
        end
      end
    end
    check("abort: second draw seen", nv, 2);
    @(posedge clk); #1;
    if (err_cfg) n_cfg_seen++;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort: busy after abort", busy, 0);
    check("abort: rnd_en after abort", rnd_en, 0);
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      if (draw_valid || done || rnd_en || busy) n_bad_out++;
      if (err_cfg) n_cfg_seen++;
    end
    check("abort: no activity afterwards", n_bad_out, 0);
    check("abort: start while busy ignored", n_cfg_seen, 0);

    // Reset asserted while the block is in WAIT.
    gen_mode = GEN_LFSR;
    cnt_cfg = 4'd4; min_cfg = 8'd10; max_cfg = 8'd20; start = 1'b1;
    got_draw = 1'b0;
    for (int cyc = 0; cyc < 2000 && !got_draw; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (draw_valid) got_draw = 1'b1;
    end
    check("rstwait: first draw seen", int'(got_draw), 1);
    @(posedge clk); #1;
    check("rstwait: busy in WAIT", busy, 1);
    check("rstwait: rnd_en low in WAIT", rnd_en, 0);
    rst_n = 1'b0;
    #1;
    check("rstwait: busy", busy, 0);
    check("rstwait: rnd_en", rnd_en, 0);
    check("rstwait: draw_valid", draw_valid, 0);
    check("rstwait: draw_num", draw_num, 0);
    check("rstwait: draw_idx", draw_idx, 0);
    check("rstwait: done", done, 0);
    check("rstwait: err_timeout", err_timeout, 0);
    check("rstwait: rnd_min", rnd_min, 0);
    check("rstwait: rnd_max", rnd_max, 255);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rstwait: idle after release", busy, 0);
    do_request(3, 30, 40, GEN_LFSR, OUT_DONE, 3, "post-reset");

    // Random requests scored by the model alone.
    for (int r = 0; r < 20; r++) begin
      int c, a, b;
      gen_mode_e m;
      c = int'($urandom_range(9, 0));
      a = int'($urandom_range(255, 0));
      if ($urandom_range(4, 0) == 0) b = int'($urandom_range(255, 0));
      else b = a + int'($urandom_range(12, 0));
      if (b > 255) b = 255;
      m = ($urandom_range(1, 0) == 0) ? GEN_LFSR : GEN_RAND;
      do_request(c, a, b, m, OUT_ANY, 0, $sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unique_draw_controller.md
UNIQUE_DRAW_CONTROLLER -- requirements
Module: unique_draw_controller

Interface
REQ-001 Parameter WIDTH, default 8: data width of random numbers and range bounds.
REQ-002 Parameter MAX_DRAWS, default 8: history depth and maximum draws per request.
REQ-003 Parameter REJECT_LIMIT, default 64: consecutive duplicate samples tolerated before abort.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of an active draw.
REQ-008 cnt_cfg  input  4  number of unique draws requested (1..MAX_DRAWS).
REQ-009 min_cfg, max_cfg  input  WIDTH  inclusive draw range.
REQ-010 rnd_en  output  1  enable to the random number generator.
REQ-011 rnd_min, rnd_max  output  WIDTH  range bounds driven to the generator.
REQ-012 rnd_num  input  WIDTH  generator output, registered by the generator on the rnd_en edge.
REQ-013 draw_valid  output  1  one-cycle pulse per accepted unique number.
REQ-014 draw_num  output  WIDTH  accepted number; held until the next accept.
REQ-015 draw_idx  output  3  index (0-based) of draw_num within the request.
REQ-016 busy, done, err_cfg, err_timeout  output  1  status; done and both err_* are one-cycle pulses.

Function
REQ-017 States SHALL be IDLE, REQ, WAIT, CHECK, FIN.
REQ-018 In IDLE, on start, the block SHALL validate: 1<=cnt_cfg<=MAX_DRAWS, max_cfg>=min_cfg, and (max_cfg-min_cfg+1)>=cnt_cfg, computed in WIDTH+1 bits.
REQ-019 If validation fails, err_cfg SHALL pulse the next cycle and the state SHALL stay IDLE.
REQ-020 If validation passes, the block SHALL latch the config, clear the history and counters, and go to REQ; busy SHALL be 1 in every state except IDLE.
REQ-021 rnd_min and rnd_max SHALL come from the latched config registers and stay constant while busy.
REQ-022 REQ SHALL assert rnd_en for exactly one cycle, then go to WAIT.
REQ-023 WAIT SHALL register rnd_num into a sample register, then go to CHECK.
REQ-024 CHECK SHALL compare the sample in parallel against all valid history entries and against the latched bounds in one cycle.
REQ-025 A unique in-range sample SHALL be written to the history at index accepted_cnt.
- The cycle after CHECK: draw_valid=1, draw_num=sample, draw_idx=accepted_cnt.
- accepted_cnt SHALL increment and the reject counter SHALL clear.
REQ-026 A duplicate or out-of-range sample SHALL increment the reject counter and return to REQ; no output changes.
REQ-027 When the reject counter reaches REQ_LIMIT (REJECT_LIMIT), the block SHALL pulse err_timeout and go to IDLE without done.
REQ-028 When accepted_cnt equals the latched count after an accept, the state SHALL go to FIN; FIN SHALL pulse done and go to IDLE.
REQ-029 Minimum latency SHALL be 3 cycles per accepted draw: REQ->WAIT->CHECK.
REQ-030 abort in any busy state SHALL force IDLE on the next edge: no draw_valid, no done, and rnd_en deasserted; abort takes priority over all other transitions.
REQ-031 start asserted while busy SHALL be ignored.

Reset
REQ-032 rst_n low SHALL asynchronously force:
- state to IDLE;
- rnd_en, draw_valid, busy, done, err_cfg, err_timeout, draw_num, draw_idx, and all counters to 0;
- the history to invalid;
- rnd_min to 0 and rnd_max to all ones.
REQ-033 Reset mid-draw SHALL discard all history; the first cycle after release SHALL be IDLE.

Structure
REQ-034 A shared package SHALL hold the state encoding, MAX_DRAWS, and REJECT_LIMIT defaults.
REQ-035 History storage SHALL be a single sub-module, draw_history: a MAX_DRAWS x WIDTH register file with valid bits, a clear input, and a combinational parallel match output.

Verification
REQ-036 Bench SHALL connect the team's LFSR random number generator and cover the following scenarios.
- cnt_cfg=4, min=10, max=20, start -> four draw_valid pulses; draw_idx 0..3; distinct values in [10,20]; then one done pulse.
- cnt_cfg=3, min=5, max=6 -> err_cfg pulse; busy stays 0; rnd_en never asserted.
- cnt_cfg=2, min=7, max=7 -> err_cfg; then cnt_cfg=1, min=7, max=7 -> single draw_num=7, then done.
- Forced generator model that repeats value 9 after the first accept -> err_timeout after 64 rejects; no done.
- abort one cycle after the second draw_valid -> IDLE next cycle; no further draw_valid; no done.
- rst_n low during WAIT -> all outputs at reset values immediately; a new start yields draw_idx starting at 0.
